mem_req_ctrl: RTL and testbench

Requester-side controller for the single-port 8-bit main memory. Accepts load/store requests from the two VLIW memory slots over valid/ready handshakes, arbitrates round-robin, drives the memory's address/data/write-enable pins one operation per cycle, and returns load data with a tag once the memory's one-cycle registered read completes. Sits between the issue stage's memory slots and the main memory array.

---
 rtl/vliw_mem_pkg.sv | 24 ++
 rtl/mem_rsp_fifo.sv | 57 +++++
 rtl/mem_req_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_req_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_mem_pkg.sv
// Shared widths and payload types for the VLIW main-memory request path.
package vliw_mem_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int TAG_W     = 2;
   localparam int NUM_SLOTS = 2;

   // One slot's request as seen by the arbiter.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [TAG_W-1:0]  tag;
   } mem_req_t;

   // One completed load, as stored in the response FIFO.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic              slot;
   } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous FIFO holding completed load responses until the consumer takes them.
// Entries reset to zero so the head reads as all-zero straight out of reset.
module mem_rsp_fifo
   import vliw_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  mem_rsp_t                     push_data,
   input  logic                         pop,
   output mem_rsp_t                     head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   mem_rsp_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Qualify push/pop against occupancy; push into a full FIFO is allowed only with a pop.
   always_comb begin
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Requester-side controller for the single-port main memory: round-robin
// arbitration of two slots, registered memory pins, load sideband pipe aligned
// with the one-cycle registered read, and a credit-checked response FIFO.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers where rsp_valid and
// rsp_ready are both high. Payloads are only sampled on the transfer edge.
module mem_req_ctrl
   import vliw_mem_pkg::*;
#(
   parameter int RSP_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_SLOTS-1:0]        req_valid,
   output logic [NUM_SLOTS-1:0]        req_ready,
   input  logic [NUM_SLOTS-1:0]        req_we,
   input  logic [NUM_SLOTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_SLOTS*DATA_W-1:0] req_wdata,
   input  logic [NUM_SLOTS*TAG_W-1:0]  req_tag,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic [TAG_W-1:0]            rsp_tag,
   output logic                        rsp_slot,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_data_in,
   output logic                        mem_write_en,
   input  logic [DATA_W-1:0]           mem_data_out,
   output logic                        dbg_rr
);

   localparam int CW  = $clog2(RSP_DEPTH + 1);
   localparam int CRW = CW + 1;

   mem_req_t               req [NUM_SLOTS];
   mem_req_t               sel;
   logic [NUM_SLOTS-1:0]   elig, grant;
   logic                   winner, accept, credit_ok;
   logic                   rr_q, rr_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic                   we_q, we_d;
   logic                   s1_v_q, s1_v_d, s1_slot_q, s2_v_q, s2_slot_q;
   logic [TAG_W-1:0]       s1_tag_q, s2_tag_q;
   logic [CW-1:0]          fifo_count;
   mem_rsp_t               push_data, head;
   logic                   pop;

   // Unpack the flat per-slot buses into request structs.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         req[i].we    = req_we[i];
         req[i].addr  = req_addr[i*ADDR_W +: ADDR_W];
         req[i].wdata = req_wdata[i*DATA_W +: DATA_W];
         req[i].tag   = req_tag[i*TAG_W +: TAG_W];
      end
   end

   // Load credits: everything in the pipe plus everything queued must fit the FIFO.
   assign credit_ok = (CRW'(s1_v_q) + CRW'(s2_v_q) + CRW'(fifo_count)) < CRW'(RSP_DEPTH);

   // Round-robin arbiter: rr is the preferred slot when both are eligible.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) elig[i] = req_valid[i] && (req_we[i] || credit_ok);
      if (elig == 2'b11) winner = rr_q;
      else               winner = elig[1];
      grant[0] = rst_n && (elig != '0) && !winner;
      grant[1] = rst_n && (elig != '0) && winner;
      accept   = grant != '0;
      sel      = req[winner];
   end

   assign req_ready = grant;

   // Next-state for pointer, memory pins and pipe entry.
   always_comb begin
      rr_d    = accept ? ~winner : rr_q;
      addr_d  = accept ? sel.addr : addr_q;
      wdata_d = accept ? sel.wdata : wdata_q;
      we_d    = accept && sel.we;
      s1_v_d  = accept && !sel.we;
   end

   // Registered state: arbiter pointer, memory pins, two-stage load sideband.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_tag_q  <= '0;
         s1_slot_q <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_tag_q  <= '0;
         s2_slot_q <= 1'b0;
      end else begin
         rr_q      <= rr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         s1_v_q    <= s1_v_d;
         s1_tag_q  <= sel.tag;
         s1_slot_q <= winner;
         s2_v_q    <= s1_v_q;
         s2_tag_q  <= s1_tag_q;
         s2_slot_q <= s1_slot_q;
      end
   end

   // The read stage lines up with the memory's registered read data.
   always_comb begin
      push_data.data = mem_data_out;
      push_data.tag  = s2_tag_q;
      push_data.slot = s2_slot_q;
   end

   assign pop = rsp_valid && rsp_ready;

   mem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (s2_v_q),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   assign rsp_valid    = fifo_count != '0;
   assign rsp_data     = head.data;
   assign rsp_tag      = head.tag;
   assign rsp_slot     = head.slot;
   assign mem_addr     = addr_q;
   assign mem_data_in  = wdata_q;
   assign mem_write_en = we_q;
   assign dbg_rr       = rr_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-port memory
// (one-cycle registered read, write on the edge after mem_write_en rises).
module tb_mem_req_ctrl;
   import vliw_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_we;
   logic [15:0] req_addr, req_wdata;
   logic [3:0]  req_tag;
   logic        rsp_valid, rsp_ready, rsp_slot, mem_write_en, dbg_rr;
   logic [7:0]  rsp_data, mem_addr, mem_data_in, mem_data_out;
   logic [1:0]  rsp_tag;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem_model [256];

   mem_req_ctrl #(.RSP_DEPTH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_tag      (req_tag),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_tag      (rsp_tag),
      .rsp_slot     (rsp_slot),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en),
      .mem_data_out (mem_data_out),
      .dbg_rr       (dbg_rr)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // memory model: read-first, registered read data
   always @(posedge clk) begin
      if (mem_write_en) mem_model[mem_addr] <= mem_data_in;
      mem_data_out <= mem_model[mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] init_val(input logic [7:0] a);
      return a ^ 8'h5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int slot, input logic v, input logic we,
                        input logic [7:0] addr, input logic [7:0] wdata, input logic [1:0] tag);
      req_valid[slot]          = v;
      req_we[slot]             = we;
      req_addr[slot*8 +: 8]    = addr;
      req_wdata[slot*8 +: 8]   = wdata;
      req_tag[slot*2 +: 2]     = tag;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [7:0] d,
                          input logic [1:0] t, input logic s);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, "_data"},  32'(rsp_data),  32'(d));
      chk({tag, "_tag"},   32'(rsp_tag),   32'(t));
      chk({tag, "_slot"},  32'(rsp_slot),  32'(s));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'h0);
      chk_rsp({tag, "_rsp"}, 1'b0, 8'h00, 2'd0, 1'b0);
      chk({tag, "_addr"},  32'(mem_addr),     32'h0);
      chk({tag, "_wdata"}, 32'(mem_data_in),  32'h0);
      chk({tag, "_we"},    32'(mem_write_en), 32'h0);
      chk({tag, "_rr"},    32'(dbg_rr),       32'h0);
   endtask

   logic [1:0] exp_rdy [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
   logic       exp_v   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = init_val(8'(i));
      mem_data_out = 8'h00;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_we    = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;

      // Reset state, with both slots requesting loads
      drive(0, 1'b1, 1'b0, 8'h01, 8'h00, 2'd1);
      drive(1, 1'b1, 1'b0, 8'h02, 8'h00, 2'd2);
      repeat (2) @(posedge clk);
      #2;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 2'b00;
      tick;

      // Store then load to the same address
      drive(0, 1'b1, 1'b1, 8'h10, 8'hA5, 2'd0);
      #1 chk("st_ready", 32'(req_ready), 32'h1);
      tick;
      chk("st_we", 32'(mem_write_en), 32'h1);
      chk("st_addr", 32'(mem_addr), 32'h10);
      chk("st_wdata", 32'(mem_data_in), 32'hA5);
      chk("st_rr", 32'(dbg_rr), 32'h1);
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
      drive(1, 1'b1, 1'b0, 8'h10, 8'h00, 2'd3);
      #1 chk("ld_ready", 32'(req_ready), 32'h2);
      tick;
      req_valid = 2'b00;
      chk("ld_we", 32'(mem_write_en), 32'h0);
      chk("ld_addr", 32'(mem_addr), 32'h10);
      chk("ld_rsp0", 32'(rsp_valid), 32'h0);
      chk("ld_rr", 32'(dbg_rr), 32'h0);
      tick;
      chk("ld_rsp1", 32'(rsp_valid), 32'h0);
      tick;
      chk_rsp("sl_rsp", 1'b1, 8'hA5, 2'd3, 1'b1);
      tick;
      chk("sl_pop", 32'(rsp_valid), 32'h0);

      // Both slots loading continuously; credits throttle to two in flight.
      // At the fourth cycle a push and a pop coincide with one entry queued.
      drive(0, 1'b1, 1'b0, 8'h20, 8'h00, 2'd1);
      drive(1, 1'b1, 1'b0, 8'h31, 8'h00, 2'd2);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("alt_ready%0d", k), 32'(req_ready), 32'(exp_rdy[k]));
         chk($sformatf("alt_valid%0d", k), 32'(rsp_valid), 32'(exp_v[k]));
         if (k == 3) chk_rsp("alt_r0", 1'b1, init_val(8'h20), 2'd1, 1'b0);
         if (k == 4) chk_rsp("alt_r1", 1'b1, init_val(8'h31), 2'd2, 1'b1);
         tick;
      end
      req_valid = 2'b00;
      #1 chk("alt_gap", 32'(rsp_valid), 32'h0);
      tick;
      chk_rsp("alt_r2", 1'b1, init_val(8'h20), 2'd1, 1'b0);
      tick;
      chk_rsp("alt_r3", 1'b1, init_val(8'h31), 2'd2, 1'b1);
      tick;
      chk("alt_empty", 32'(rsp_valid), 32'h0);

      // Consumer stalled: two loads fill the credits, stores still go through
      rsp_ready = 1'b0;
      drive(0, 1'b1, 1'b0, 8'h40, 8'h00, 2'd1);
      #1 chk("bp_ready0", 32'(req_ready), 32'h1);
      tick;
      drive(0, 1'b1, 1'b0, 8'h41, 8'h00, 2'd2);
      #1 chk("bp_ready1", 32'(req_ready), 32'h1);
      chk("bp_rr1", 32'(dbg_rr), 32'h1);
      tick;
      drive(0, 1'b1, 1'b0, 8'h42, 8'h00, 2'd3);
      drive(1, 1'b1, 1'b1, 8'h50, 8'hC3, 2'd0);
      #1 chk("bp_ready2", 32'(req_ready), 32'h2);
      tick;
      chk("bp_we3", 32'(mem_write_en), 32'h1);
      chk("bp_addr3", 32'(mem_addr), 32'h50);
      chk("bp_wdata3", 32'(mem_data_in), 32'hC3);
      chk("bp_valid3", 32'(rsp_valid), 32'h1);
      drive(1, 1'b1, 1'b1, 8'h51, 8'hC4, 2'd0);
      #1 chk("bp_ready3", 32'(req_ready), 32'h2);
      tick;
      chk("bp_we4", 32'(mem_write_en), 32'h1);
      chk("bp_addr4", 32'(mem_addr), 32'h51);
      chk("bp_wdata4", 32'(mem_data_in), 32'hC4);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
      #1 chk("bp_ready4", 32'(req_ready), 32'h0);
      chk_rsp("bp_head4", 1'b1, init_val(8'h40), 2'd1, 1'b0);
      tick;
      chk("bp_we5", 32'(mem_write_en), 32'h0);
      chk_rsp("bp_head5", 1'b1, init_val(8'h40), 2'd1, 1'b0);
      rsp_ready = 1'b1;
      #1 chk("bp_ready5", 32'(req_ready), 32'h0);
      tick;
      #1 chk("bp_ready6", 32'(req_ready), 32'h1);
      chk_rsp("bp_head6", 1'b1, init_val(8'h41), 2'd2, 1'b0);
      tick;
      req_valid = 2'b00;
      #1 chk("bp_valid7", 32'(rsp_valid), 32'h0);
      chk("bp_addr7", 32'(mem_addr), 32'h42);
      tick;
      chk("bp_valid8", 32'(rsp_valid), 32'h0);
      tick;
      chk_rsp("bp_head9", 1'b1, init_val(8'h42), 2'd3, 1'b0);
      tick;

      // Idle: pins hold, no write pulses, pointer unchanged
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("idle_we%0d", k), 32'(mem_write_en), 32'h0);
         chk($sformatf("idle_addr%0d", k), 32'(mem_addr), 32'h42);
         chk($sformatf("idle_rr%0d", k), 32'(dbg_rr), 32'h1);
         tick;
      end

      // Reset with two loads in flight
      drive(0, 1'b1, 1'b0, 8'h60, 8'h00, 2'd1);
      tick;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
      drive(1, 1'b1, 1'b0, 8'h61, 8'h00, 2'd2);
      tick;
      drive(0, 1'b1, 1'b0, 8'h62, 8'h00, 2'd3);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("mid");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 2'b00;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("post_valid%0d", k), 32'(rsp_valid), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
